// File: rtl/coinc_pkg.sv
// rtl/coinc_pkg.sv - shared channel/coincidence indices and counter width for the coincidence datapath
package coinc_pkg;

  localparam int NUM_CH = 4;
  localparam int NUM_CO = 5;

  localparam int CH_A = 0;
  localparam int CH_B = 1;
  localparam int CH_C = 2;
  localparam int CH_D = 3;

  localparam int CO_AB  = 0;
  localparam int CO_AC  = 1;
  localparam int CO_DB  = 2;
  localparam int CO_DC  = 3;
  localparam int CO_ABC = 4;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef logic [CNT_W-1:0] cnt_t;

  // An accepted edge on one side pairs with an accepted edge or open window on the other;
  // simultaneous edges fold into the first term so they count once.
  function automatic logic pair_evt(input logic acc_x, input logic open_x,
                                    input logic acc_y, input logic open_y);
    return (acc_x & (acc_y | open_y)) | (acc_y & open_x);
  endfunction

endpackage

// File: rtl/detector_pulse_conditioner_if.sv
// rtl/detector_pulse_conditioner_if.sv - detector inputs and event strobe bundle
interface detector_pulse_conditioner_if;
  import coinc_pkg::*;

  logic              enable;
  logic [NUM_CH-1:0] det_in;
  logic [NUM_CH-1:0] single_evt;
  logic [NUM_CO-1:0] coinc_evt;
  logic [NUM_CH-1:0] win_open;

  modport master (output enable, det_in, input single_evt, coinc_evt, win_open);
  modport slave  (input enable, det_in, output single_evt, coinc_evt, win_open);

endinterface

// File: rtl/detector_pulse_conditioner_channel_front_end.sv
// rtl/detector_pulse_conditioner_channel_front_end.sv - per-channel synchroniser, edge detect, dead time and window
module channel_front_end
  import coinc_pkg::*;
#(
  parameter int WINDOW_CYC = 2,
  parameter int DEAD_CYC   = 0
) (
  input  logic clock_50,
  input  logic rst_n,
  input  logic enable,
  input  logic det_in,
  output logic acc,
  output logic win_open
);

  localparam cnt_t WIN_LOAD  = cnt_t'(WINDOW_CYC);
  localparam cnt_t DEAD_LOAD = cnt_t'(DEAD_CYC);

  logic sync1;
  logic sync2;
  logic prev;
  logic raw_edge;
  cnt_t dead_cnt;
  cnt_t win_cnt;

  assign raw_edge = sync2 & ~prev;
  assign acc      = raw_edge & enable & (dead_cnt == '0);
  assign win_open = (win_cnt != '0);

  // Two-flop synchroniser plus one delayed copy for rising-edge detection.
  always_ff @(posedge clock_50) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= det_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Dead-time counter: reloaded by every accepted edge, saturates at zero.
  always_ff @(posedge clock_50) begin
    if (!rst_n) begin
      dead_cnt <= '0;
    end else if (acc) begin
      dead_cnt <= DEAD_LOAD;
    end else if (dead_cnt != '0) begin
      dead_cnt <= dead_cnt - cnt_t'(1);
    end
  end

  // Coincidence window: an accepted edge (re)opens it for WINDOW_CYC following cycles.
  always_ff @(posedge clock_50) begin
    if (!rst_n) begin
      win_cnt <= '0;
    end else if (acc) begin
      win_cnt <= WIN_LOAD;
    end else if (win_cnt != '0) begin
      win_cnt <= win_cnt - cnt_t'(1);
    end
  end

endmodule

// File: rtl/detector_pulse_conditioner.sv
// rtl/detector_pulse_conditioner.sv - four-channel detector conditioning with registered single and coincidence strobes
module detector_pulse_conditioner
  import coinc_pkg::*;
#(
  parameter int WINDOW_CYC = 2,
  parameter int DEAD_CYC   = 0
) (
  input logic                         clock_50,
  input logic                         rst_n,
  detector_pulse_conditioner_if.slave bus
);

  if (WINDOW_CYC < 1 || WINDOW_CYC > CNT_MAX || DEAD_CYC < 0 || DEAD_CYC > CNT_MAX) begin : g_bad_param
    $error("detector_pulse_conditioner: WINDOW_CYC must be 1..255 and DEAD_CYC 0..255");
  end

  logic [NUM_CH-1:0] acc;
  logic [NUM_CH-1:0] open_w;
  logic [NUM_CO-1:0] coinc_next;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    channel_front_end #(
      .WINDOW_CYC(WINDOW_CYC),
      .DEAD_CYC  (DEAD_CYC)
    ) u_fe (
      .clock_50(clock_50),
      .rst_n   (rst_n),
      .enable  (bus.enable),
      .det_in  (bus.det_in[i]),
      .acc     (acc[i]),
      .win_open(open_w[i])
    );
  end

  // Pair and triple coincidences from this cycle's accepted edges and open windows.
  always_comb begin
    coinc_next = '0;
    coinc_next[CO_AB] = pair_evt(acc[CH_A], open_w[CH_A], acc[CH_B], open_w[CH_B]);
    coinc_next[CO_AC] = pair_evt(acc[CH_A], open_w[CH_A], acc[CH_C], open_w[CH_C]);
    coinc_next[CO_DB] = pair_evt(acc[CH_D], open_w[CH_D], acc[CH_B], open_w[CH_B]);
    coinc_next[CO_DC] = pair_evt(acc[CH_D], open_w[CH_D], acc[CH_C], open_w[CH_C]);
    coinc_next[CO_ABC] = (acc[CH_A] | acc[CH_B] | acc[CH_C])
                       & (acc[CH_A] | open_w[CH_A])
                       & (acc[CH_B] | open_w[CH_B])
                       & (acc[CH_C] | open_w[CH_C]);
  end

  // Output registers so every strobe is a clean single-cycle pulse.
  always_ff @(posedge clock_50) begin
    if (!rst_n) begin
      bus.single_evt <= '0;
      bus.coinc_evt  <= '0;
      bus.win_open   <= '0;
    end else begin
      bus.single_evt <= acc;
      bus.coinc_evt  <= coinc_next;
      bus.win_open   <= open_w;
    end
  end

endmodule
